// File: rtl/fp_addsub_pipe.sv
`timescale 1ns/1ps
// fp_addsub_pipe: pipelined floating-point adder/subtractor (capture, align, add, normalise/round)
// with round-to-nearest-even, special values and a valid/ready stream interface.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] sum,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int W   = EXP_W + MAN_W + 1;
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW + 1);
    localparam int EW2 = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;

    logic           s1Valid_q;
    logic [W-1:0]   s1A_q, s1B_q;

    logic             s2Valid_q, s2Sign_q, s2Sub_q, s2Nan_q, s2Inf_q, s2InfSign_q, s2NegZero_q;
    logic [EXP_W-1:0] s2Exp_q;
    logic [SW-1:0]    s2SigX_q, s2SigY_q;

    logic             s3Valid_q, s3Sign_q, s3Nan_q, s3Inf_q, s3InfSign_q, s3NegZero_q;
    logic [EXP_W-1:0] s3Exp_q;
    logic [SW:0]      s3Mag_q;

    logic           outValid_q, overflow_q, underflow_q;
    logic [W-1:0]   sum_q;

    assign adv       = !outValid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = outValid_q;
    assign sum       = sum_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Unpack and classify the captured operands
    logic             signA, signB, zeroA, zeroB, infA, infB, nanA, nanB, swap;
    logic [EXP_W-1:0] expA, expB, expX, expY, expDiff;
    logic [MAN_W-1:0] fracA, fracB;
    logic [MAN_W:0]   sigA, sigB, sigX, sigY;
    logic [2*SW-1:0]  shiftWide;
    logic [SW-1:0]    alignY_d;

    assign signA = s1A_q[W-1];
    assign signB = s1B_q[W-1];
    assign expA  = s1A_q[W-2:MAN_W];
    assign expB  = s1B_q[W-2:MAN_W];
    assign fracA = s1A_q[MAN_W-1:0];
    assign fracB = s1B_q[MAN_W-1:0];
    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);
    assign infA  = (expA == EXP_MAX) && (fracA == '0);
    assign infB  = (expB == EXP_MAX) && (fracB == '0);
    assign nanA  = (expA == EXP_MAX) && (fracA != '0);
    assign nanB  = (expB == EXP_MAX) && (fracB != '0);
    assign sigA  = zeroA ? '0 : {1'b1, fracA};
    assign sigB  = zeroB ? '0 : {1'b1, fracB};

    assign swap    = {expB, sigB[MAN_W-1:0]} > {expA, sigA[MAN_W-1:0]};
    assign expX    = swap ? expB : expA;
    assign expY    = swap ? expA : expB;
    assign sigX    = swap ? sigB : sigA;
    assign sigY    = swap ? sigA : sigB;
    assign expDiff = expX - expY;

    // The lower half of the wide shift catches every bit that falls past the sticky position
    assign shiftWide = {sigY, 3'b000, {SW{1'b0}}} >> expDiff;

    always_comb begin
        if (32'(expDiff) >= SW)
            alignY_d = {{(SW-1){1'b0}}, |sigY};
        else
            alignY_d = {shiftWide[2*SW-1:SW+1], shiftWide[SW] | (|shiftWide[SW-1:0])};
    end

    logic [SW:0] mag_d;
    assign mag_d = s2Sub_q ? ({1'b0, s2SigX_q} - {1'b0, s2SigY_q})
                           : ({1'b0, s2SigX_q} + {1'b0, s2SigY_q});

    // Normalise: highest set bit below the carry position decides the left shift
    logic [LZW-1:0]   lzc;
    logic             carry, roundUp, roundCarry;
    logic [SW-1:0]    norm;
    logic [EW2-1:0]   expNorm, expFinal;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W-1:0] fracOut;

    always_comb begin
        lzc = '0;
        for (int i = 0; i < SW; i++)
            if (s3Mag_q[i]) lzc = LZW'(SW - 1 - i);
    end

    assign carry = s3Mag_q[SW];

    always_comb begin
        if (carry) begin
            norm    = {s3Mag_q[SW:2], s3Mag_q[1] | s3Mag_q[0]};
            expNorm = {2'b00, s3Exp_q} + EW2'(1);
        end else begin
            norm    = s3Mag_q[SW-1:0] << lzc;
            expNorm = {2'b00, s3Exp_q} - EW2'(lzc);
        end
    end

    assign roundUp    = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign rounded    = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(roundUp);
    assign roundCarry = rounded[MAN_W+1];
    assign fracOut    = roundCarry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    assign expFinal   = expNorm + EW2'(roundCarry);

    logic [W-1:0] sum_d;
    logic         overflow_d, underflow_d;

    always_comb begin
        sum_d       = {s3Sign_q, expFinal[EXP_W-1:0], fracOut};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (s3Nan_q) begin
            sum_d = QNAN;
        end else if (s3Inf_q) begin
            sum_d = {s3InfSign_q, EXP_MAX, {MAN_W{1'b0}}};
        end else if (s3Mag_q == '0) begin
            sum_d = {s3NegZero_q, {(W-1){1'b0}}};
        end else if (!expFinal[EW2-1] && (expFinal >= {2'b00, EXP_MAX})) begin
            sum_d      = {s3Sign_q, EXP_MAX, {MAN_W{1'b0}}};
            overflow_d = 1'b1;
        end else if (expFinal[EW2-1] || (expFinal == '0)) begin
            sum_d       = {s3Sign_q, {(W-1){1'b0}}};
            underflow_d = 1'b1;
        end
    end

    // Every stage moves together; a stalled output freezes the whole pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            s2Valid_q   <= 1'b0;
            s3Valid_q   <= 1'b0;
            outValid_q  <= 1'b0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (adv) begin
            s1Valid_q   <= in_valid;
            s1A_q       <= a;
            s1B_q       <= b ^ {op, {(W-1){1'b0}}};

            s2Valid_q   <= s1Valid_q;
            s2Sign_q    <= swap ? signB : signA;
            s2Sub_q     <= signA ^ signB;
            s2Exp_q     <= expX;
            s2SigX_q    <= {sigX, 3'b000};
            s2SigY_q    <= alignY_d;
            s2Nan_q     <= nanA | nanB | (infA & infB & (signA ^ signB));
            s2Inf_q     <= infA | infB;
            s2InfSign_q <= infA ? signA : signB;
            s2NegZero_q <= zeroA & zeroB & signA & signB;

            s3Valid_q   <= s2Valid_q;
            s3Sign_q    <= s2Sign_q;
            s3Exp_q     <= s2Exp_q;
            s3Mag_q     <= mag_d;
            s3Nan_q     <= s2Nan_q;
            s3Inf_q     <= s2Inf_q;
            s3InfSign_q <= s2InfSign_q;
            s3NegZero_q <= s2NegZero_q;

            outValid_q  <= s3Valid_q;
            if (s3Valid_q) begin
                sum_q       <= sum_d;
                overflow_q  <= overflow_d;
                underflow_q <= underflow_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
`timescale 1ns/1ps
// Directed bench for fp_addsub_pipe: binary32 build plus a binary16 build sharing clock and reset.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady, op, outValid, outReady, overflow, underflow;
    logic [31:0] a, b, sum;
    logic        hInValid, hInReady, hOp, hOutValid, hOutReady, hOverflow, hUnderflow;
    logic [15:0] hA, hB, hSum;

    int checks   = 0;
    int failures = 0;

    logic [31:0] bpA[6]   = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40800000, 32'h40400000};
    logic [31:0] bpB[6]   = '{32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h40800000, 32'h3F800000};
    logic        bpOp[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] bpExp[6] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h41000000, 32'h40000000};

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .a(a), .b(b), .op(op),
        .out_valid(outValid), .out_ready(outReady), .sum(sum), .overflow(overflow), .underflow(underflow)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dutHalf (
        .clk(clk), .rst(rst), .in_valid(hInValid), .in_ready(hInReady), .a(hA), .b(hB), .op(hOp),
        .out_valid(hOutValid), .out_ready(hOutReady), .sum(hSum), .overflow(hOverflow), .underflow(hUnderflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation, then wait a bounded time for its result and check latency, value and flags
    task automatic applyStimulus(input string tag, input bit useHalf, input logic [31:0] opA,
                                 input logic [31:0] opB, input logic opSel, input logic [31:0] expSum,
                                 input logic expOvf, input logic expUnf);
        int   n;
        logic vld;
        @(negedge clk);
        if (useHalf) begin
            hInValid = 1'b1; hA = opA[15:0]; hB = opB[15:0]; hOp = opSel;
        end else begin
            inValid = 1'b1; a = opA; b = opB; op = opSel;
        end
        #1;
        checkOutput({tag, ".ready"}, 32'(useHalf ? hInReady : inReady), 32'd1);
        @(negedge clk);
        inValid  = 1'b0;
        hInValid = 1'b0;
        n   = 0;
        vld = useHalf ? hOutValid : outValid;
        while (!vld && n < 10) begin
            @(negedge clk);
            n++;
            vld = useHalf ? hOutValid : outValid;
        end
        checkOutput({tag, ".latency"}, 32'(n), 32'd3);
        checkOutput({tag, ".sum"}, useHalf ? 32'(hSum) : sum, expSum);
        checkOutput({tag, ".ovf"}, 32'(useHalf ? hOverflow : overflow), 32'(expOvf));
        checkOutput({tag, ".unf"}, 32'(useHalf ? hUnderflow : underflow), 32'(expUnf));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent, got;
        rst = 1'b1; inValid = 1'b0; a = '0; b = '0; op = 1'b0; outReady = 1'b1;
        hInValid = 1'b0; hA = '0; hB = '0; hOp = 1'b0; hOutReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset.outValid", 32'(outValid), 32'd0);
        checkOutput("reset.sum", sum, 32'd0);
        checkOutput("reset.ovf", 32'(overflow), 32'd0);
        checkOutput("reset.unf", 32'(underflow), 32'd0);
        checkOutput("reset.inReady", 32'(inReady), 32'd1);

        applyStimulus("add",       0, 32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 1'b0);
        applyStimulus("sub",       0, 32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 1'b0, 1'b0);
        applyStimulus("cancel",    0, 32'hC0933333, 32'h40933333, 1'b0, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("tieEven",   0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        applyStimulus("roundUp",   0, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        applyStimulus("renorm",    0, 32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 1'b0, 1'b0);
        applyStimulus("overflow",  0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        applyStimulus("underflow", 0, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1);
        applyStimulus("infMinusInf", 0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
        applyStimulus("nanIn",     0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
        applyStimulus("singleInf", 0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
        applyStimulus("negZeros",  0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
        applyStimulus("stickySub", 0, 32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
        applyStimulus("halfAdd",   1, 32'h00003C00, 32'h00003800, 1'b0, 32'h00003E00, 1'b0, 1'b0);
        applyStimulus("halfOvf",   1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 1'b1, 1'b0);

        // Six back-to-back ops with the consumer stalled on cycles 4..7
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            outReady = !(c >= 4 && c <= 7);
            if (sent < 6) begin
                inValid = 1'b1; a = bpA[sent]; b = bpB[sent]; op = bpOp[sent];
            end else begin
                inValid = 1'b0;
            end
            #1;
            checkOutput($sformatf("bp.inReady%0d", c), 32'(inReady), (c >= 4 && c <= 7) ? 32'd0 : 32'd1);
            if (outValid) begin
                if (got < 6) checkOutput($sformatf("bp.sum%0d", c), sum, bpExp[got]);
                if (outReady) got++;
            end
            if (inValid && inReady) sent++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("bp.delivered", 32'(got), 32'd6);
        checkOutput("bp.sent", 32'(sent), 32'd6);

        // Reset lands on the third issue cycle; nothing in flight may emerge
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inValid = 1'b1; a = bpA[c]; b = bpB[c]; op = bpOp[c];
            rst = (c == 2);
        end
        @(negedge clk);
        rst = 1'b0;
        inValid = 1'b0;
        #1;
        checkOutput("rstMid.inReady", 32'(inReady), 32'd1);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("rstMid.outValid%0d", c), 32'(outValid), 32'd0);
            @(negedge clk);
        end
        applyStimulus("postReset", 0, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
